ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL be the maximum REQ-state cycles waiting for mem_ack before error (range 2..256).
REQ-002 clk  input  1  SHALL be the clock; all state updates on the rising edge.
REQ-003 reset  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 pc_addr  input  32  SHALL be the current fetch address from the program counter.
REQ-005 pc_stall  output  1  SHALL hold the program counter when high (combinational).
REQ-006 mem_req  output  1  SHALL be the instruction-memory request strobe (registered).
REQ-007 mem_addr  output  32  SHALL be the request address (registered).
REQ-008 mem_ack  input  1  SHALL signal that mem_rdata is valid this cycle.
REQ-009 mem_rdata  input  32  SHALL carry the instruction word returned by memory.
REQ-010 flush  input  1  SHALL abort any fetch on a branch/jump redirect.
REQ-011 instr  output  32  SHALL be the fetched instruction (registered).
REQ-012 instr_addr  output  32  SHALL be the address of instr (registered).
REQ-013 instr_valid  output  1  SHALL mark instr/instr_addr valid (registered).
REQ-014 instr_ready  input  1  SHALL be decode's acceptance of instr.
REQ-015 fetch_err  output  1  SHALL flag a misaligned address or a memory timeout (registered, sticky).

Function
REQ-016 FSM states SHALL be IDLE, REQ, HOLD, ERR.
REQ-017 IDLE: next edge SHALL latch mem_addr=pc_addr, set mem_req=1, go to REQ; if pc_addr[1:0]!=0, go to ERR with fetch_err=1 and mem_req=0.
REQ-018 REQ: mem_req and mem_addr SHALL stay constant until exit; a wait counter SHALL clear on entry and increment each REQ cycle without mem_ack.
REQ-019 REQ with mem_ack=1: next edge SHALL latch instr=mem_rdata, instr_addr=mem_addr, set instr_valid=1, clear mem_req, go to HOLD.
REQ-020 REQ, no mem_ack, counter==TIMEOUT-1: next edge SHALL clear mem_req, set fetch_err=1, go to ERR; ack on that same cycle SHALL win over timeout.
REQ-021 HOLD: instr, instr_addr, instr_valid SHALL stay constant until instr_ready=1; then next edge SHALL clear instr_valid and go to IDLE.
REQ-022 pc_stall SHALL be 0 only when state==HOLD, instr_ready=1 and flush=0; 1 otherwise, so the PC advances exactly once per accepted instruction.
REQ-023 Minimum throughput SHALL be one instruction per 3 cycles (IDLE, REQ with immediate ack, HOLD with ready).
REQ-024 flush=1 at an edge, any state: SHALL go to IDLE, clear mem_req, instr_valid and fetch_err; a mem_ack in the same cycle SHALL be discarded.
REQ-025 ERR: mem_req=0, instr_valid=0, fetch_err=1 SHALL hold until flush or reset.
REQ-026 mem_ack outside REQ SHALL be ignored.
REQ-027 Address arithmetic SHALL be none; addresses pass through unmodified at 32 bits.

Reset
REQ-028 reset=0 at an edge SHALL set state=IDLE, mem_req=0, mem_addr=0, instr=0, instr_addr=0, instr_valid=0, fetch_err=0, counter=0.
REQ-029 Reset SHALL take priority over flush, mem_ack and instr_ready, including mid-fetch (REQ) and mid-hold (HOLD).
REQ-030 pc_stall SHALL be 1 while reset=0.

Verification
REQ-031 pc_addr=0x0, mem_ack=1 one cycle after mem_req, mem_rdata=0x20080005, instr_ready=1 -> mem_req one cycle; instr_valid=1 with instr=0x20080005, instr_addr=0x0 one cycle; pc_stall=0 that cycle only; repeats every 3 cycles.
REQ-032 pc_addr=0x10, mem_ack delayed 5 cycles, instr_ready low 3 cycles in HOLD -> mem_addr=0x10 held 6 cycles; instr held 4 cycles; pc_stall=1 throughout except the accept cycle.
REQ-033 TIMEOUT=16, mem_ack never asserted -> mem_req high exactly 16 cycles, then fetch_err=1 and state ERR; flush pulse -> fetch_err=0, new request next-but-one cycle.
REQ-034 pc_addr=0x6 -> fetch_err=1 one edge after IDLE, mem_req never asserted.
REQ-035 flush and mem_ack together in REQ with mem_rdata=0xDEADBEEF -> instr_valid stays 0, instr unchanged, new request from current pc_addr (e.g. 0x40 after jump).
REQ-036 reset=0 for 2 cycles while in HOLD with instr_valid=1 -> all outputs zero on next edge, pc_stall=1; fetch restarts from pc_addr after release.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues one aligned fetch per program-counter value,
// waits (with timeout) for memory, presents the word to decode, and holds
// the PC until decode accepts it. Misalignment and timeouts park in ERR
// until a flush redirects the fetch stream.
module ifetch_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_addr,
    output logic        pc_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        flush,
    output logic [31:0] instr,
    output logic [31:0] instr_addr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_err
);

    // Wait counter only needs to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        ERR
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] wait_cnt, wait_cnt_next;
    logic          mem_req_next;
    logic [31:0]   mem_addr_next;
    logic [31:0]   instr_next;
    logic [31:0]   instr_addr_next;
    logic          instr_valid_next;
    logic          fetch_err_next;

    // The PC may advance only on the cycle decode takes the held instruction.
    assign pc_stall = !(reset && !flush && instr_ready && (state == HOLD));

    // Next-state and next-output computation; flush overrides every state.
    always_comb begin
        state_next       = state;
        wait_cnt_next    = wait_cnt;
        mem_req_next     = mem_req;
        mem_addr_next    = mem_addr;
        instr_next       = instr;
        instr_addr_next  = instr_addr;
        instr_valid_next = instr_valid;
        fetch_err_next   = fetch_err;

        if (flush) begin
            state_next       = IDLE;
            wait_cnt_next    = '0;
            mem_req_next     = 1'b0;
            instr_valid_next = 1'b0;
            fetch_err_next   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mem_addr_next = pc_addr;
                    wait_cnt_next = '0;
                    if (pc_addr[1:0] != 2'b00) begin
                        state_next     = ERR;
                        mem_req_next   = 1'b0;
                        fetch_err_next = 1'b1;
                    end else begin
                        state_next   = REQ;
                        mem_req_next = 1'b1;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state_next       = HOLD;
                        instr_next       = mem_rdata;
                        instr_addr_next  = mem_addr;
                        instr_valid_next = 1'b1;
                        mem_req_next     = 1'b0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_next     = ERR;
                        mem_req_next   = 1'b0;
                        fetch_err_next = 1'b1;
                    end else begin
                        wait_cnt_next = wait_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        state_next       = IDLE;
                        instr_valid_next = 1'b0;
                    end
                end
                ERR: begin
                    mem_req_next     = 1'b0;
                    instr_valid_next = 1'b0;
                    fetch_err_next   = 1'b1;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            instr       <= '0;
            instr_addr  <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_cnt_next;
            mem_req     <= mem_req_next;
            mem_addr    <= mem_addr_next;
            instr       <= instr_next;
            instr_addr  <= instr_addr_next;
            instr_valid <= instr_valid_next;
            fetch_err   <= fetch_err_next;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a fetch-level reference model is checked
// against the DUT every cycle, and literal expectations pin key scenarios.
module tb_ifetch_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_addr;
    logic        pc_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        flush;
    logic [31:0] instr;
    logic [31:0] instr_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    ifetch_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_addr    (pc_addr),
        .pc_stall   (pc_stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .flush      (flush),
        .instr      (instr),
        .instr_addr (instr_addr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .fetch_err  (fetch_err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference model: what the fetch unit is doing, described as activity.
    localparam int M_IDLE = 0, M_WAITING = 1, M_PRESENTING = 2, M_FAULTED = 3;
    int          m_activity = M_IDLE;
    int          m_waited = 0;
    bit          m_known = 1'b0;
    bit          m_req = 1'b0, m_valid = 1'b0, m_err = 1'b0;
    logic [31:0] m_addr = '0, m_instr = '0, m_iaddr = '0;
    logic        last_stall;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance the model on every rising edge from the inputs seen at that edge.
    always @(posedge clk) begin
        if (!reset) begin
            m_known = 1'b1; m_activity = M_IDLE; m_waited = 0;
            m_req = 0; m_valid = 0; m_err = 0;
            m_addr = '0; m_instr = '0; m_iaddr = '0;
        end else if (m_known) begin
            if (flush) begin
                m_activity = M_IDLE; m_req = 0; m_valid = 0; m_err = 0; m_waited = 0;
            end else if (m_activity == M_IDLE) begin
                m_addr = pc_addr;
                m_waited = 0;
                if (pc_addr % 4 != 0) begin
                    m_activity = M_FAULTED; m_err = 1; m_req = 0;
                end else begin
                    m_activity = M_WAITING; m_req = 1;
                end
            end else if (m_activity == M_WAITING) begin
                if (mem_ack) begin
                    m_instr = mem_rdata; m_iaddr = m_addr; m_valid = 1; m_req = 0;
                    m_activity = M_PRESENTING;
                end else if (m_waited + 1 == TIMEOUT) begin
                    m_req = 0; m_err = 1; m_activity = M_FAULTED;
                end else begin
                    m_waited = m_waited + 1;
                end
            end else if (m_activity == M_PRESENTING) begin
                if (instr_ready) begin
                    m_valid = 0; m_activity = M_IDLE;
                end
            end
        end
    end

    // Compare DUT against the model shortly after every edge.
    always @(posedge clk) begin
        #2;
        if (m_known) begin
            check_output("mem_req",     32'(mem_req),     32'(m_req));
            check_output("mem_addr",    mem_addr,         m_addr);
            check_output("instr",       instr,            m_instr);
            check_output("instr_addr",  instr_addr,       m_iaddr);
            check_output("instr_valid", 32'(instr_valid), 32'(m_valid));
            check_output("fetch_err",   32'(fetch_err),   32'(m_err));
            check_output("pc_stall",    32'(pc_stall),
                         32'(!(reset && !flush && instr_ready && m_activity == M_PRESENTING)));
        end
    end

    // Drive one cycle of inputs at the falling edge, then observe after the next rise.
    task automatic apply_stimulus(input logic [31:0] pc, input logic ack, input logic [31:0] rdata,
                                  input logic fl, input logic rdy, input logic rst_n);
        @(negedge clk);
        pc_addr = pc; mem_ack = ack; mem_rdata = rdata; flush = fl; instr_ready = rdy; reset = rst_n;
        #1 last_stall = pc_stall;
        @(posedge clk);
        #3;
    endtask

    // Directed scenarios.
    initial begin
        int hi;
        reset = 1'b0; pc_addr = '0; mem_ack = 0; mem_rdata = '0; flush = 0; instr_ready = 0;

        // Reset state.
        apply_stimulus(32'h0, 1, 32'hFFFF_FFFF, 1, 1, 0);
        apply_stimulus(32'h0, 0, 32'h0, 0, 0, 0);
        check_output("rst_stall", 32'(last_stall), 32'd1);
        check_output("rst_req", 32'(mem_req), 32'd0);
        check_output("rst_valid", 32'(instr_valid), 32'd0);
        check_output("rst_instr", instr, 32'h0);

        // Back-to-back fetches at full rate.
        for (int k = 0; k < 2; k++) begin
            apply_stimulus(32'h0, 0, 32'h0, 0, 1, 1);
            check_output("fast_req", 32'(mem_req), 32'd1);
            check_output("fast_stall_idle", 32'(last_stall), 32'd1);
            apply_stimulus(32'h0, 1, 32'h2008_0005, 0, 1, 1);
            check_output("fast_instr", instr, 32'h2008_0005);
            check_output("fast_valid", 32'(instr_valid), 32'd1);
            check_output("fast_req_drop", 32'(mem_req), 32'd0);
            apply_stimulus(32'h0, 0, 32'h0, 0, 1, 1);
            check_output("fast_accept_stall", 32'(last_stall), 32'd0);
            check_output("fast_valid_drop", 32'(instr_valid), 32'd0);
        end

        // Slow memory and slow decode.
        apply_stimulus(32'h10, 0, 32'h0, 0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(32'h10, 0, 32'h0, 0, 0, 1);
            check_output("slow_addr", mem_addr, 32'h10);
            check_output("slow_req", 32'(mem_req), 32'd1);
        end
        apply_stimulus(32'h10, 1, 32'hCAFE_0001, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(32'h10, 0, 32'h0, 0, 0, 1);
            check_output("slow_hold_stall", 32'(last_stall), 32'd1);
            check_output("slow_hold_iaddr", instr_addr, 32'h10);
        end
        apply_stimulus(32'h10, 0, 32'h0, 0, 1, 1);
        check_output("slow_accept_stall", 32'(last_stall), 32'd0);

        // Memory timeout.
        hi = 0;
        apply_stimulus(32'h20, 0, 32'h0, 0, 0, 1);
        if (mem_req) hi++;
        for (int i = 0; i < 40 && mem_req; i++) begin
            apply_stimulus(32'h20, 0, 32'h0, 0, 0, 1);
            if (mem_req) hi++;
        end
        check_output("timeout_req_cycles", hi, 32'd16);
        check_output("timeout_err", 32'(fetch_err), 32'd1);
        apply_stimulus(32'h20, 1, 32'h5555_5555, 0, 1, 1);
        check_output("err_ignores_ack", 32'(instr_valid), 32'd0);
        apply_stimulus(32'h20, 0, 32'h0, 1, 0, 1);
        check_output("flush_clears_err", 32'(fetch_err), 32'd0);
        check_output("flush_no_req", 32'(mem_req), 32'd0);
        apply_stimulus(32'h20, 0, 32'h0, 0, 0, 1);
        check_output("refetch_req", 32'(mem_req), 32'd1);
        apply_stimulus(32'h20, 1, 32'h1111_2222, 0, 0, 1);
        apply_stimulus(32'h20, 0, 32'h0, 0, 1, 1);

        // Misaligned PC.
        apply_stimulus(32'h6, 0, 32'h0, 0, 0, 1);
        check_output("misalign_err", 32'(fetch_err), 32'd1);
        check_output("misalign_req", 32'(mem_req), 32'd0);
        apply_stimulus(32'h6, 0, 32'h0, 0, 0, 1);
        check_output("misalign_req_stays", 32'(mem_req), 32'd0);
        apply_stimulus(32'h6, 0, 32'h0, 1, 0, 1);

        // Flush colliding with an ack: the ack is dropped.
        apply_stimulus(32'h30, 0, 32'h0, 0, 0, 1);
        apply_stimulus(32'h40, 1, 32'hDEAD_BEEF, 1, 0, 1);
        check_output("flush_ack_valid", 32'(instr_valid), 32'd0);
        check_output("flush_ack_instr", instr, 32'h1111_2222);
        apply_stimulus(32'h40, 0, 32'h0, 0, 0, 1);
        check_output("jump_addr", mem_addr, 32'h40);
        apply_stimulus(32'h40, 1, 32'h3333_4444, 0, 0, 1);
        check_output("jump_instr", instr, 32'h3333_4444);

        // Reset during HOLD, then restart.
        apply_stimulus(32'h40, 1, 32'h0, 1, 1, 0);
        check_output("hold_rst_stall", 32'(last_stall), 32'd1);
        check_output("hold_rst_valid", 32'(instr_valid), 32'd0);
        check_output("hold_rst_instr", instr, 32'h0);
        apply_stimulus(32'h40, 1, 32'h0, 0, 1, 0);
        apply_stimulus(32'h50, 0, 32'h0, 0, 0, 1);
        check_output("restart_addr", mem_addr, 32'h50);
        check_output("restart_req", 32'(mem_req), 32'd1);
        apply_stimulus(32'h50, 1, 32'h7777_8888, 0, 1, 1);
        apply_stimulus(32'h50, 0, 32'h0, 0, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
